// File: rtl/conv3x3_window_feeder.sv
// Line-buffered 3x3 window feeder: streams each window as 9 back-to-back (pixel, weight) pairs.
// Build option: define FEEDER_STRIDE2_EN for stride 2 in both axes (default stride 1).
module conv3x3_window_feeder #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              w_we,
    input  logic [3:0]        w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] pe_in,
    output logic [DATA_W-1:0] pe_filter,
    output logic              feed_valid,
    output logic              window_start,
    output logic              window_last,
    output logic              frame_done
);

`ifdef FEEDER_STRIDE2_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif
    localparam int CW = $clog2(IMG_W);
    localparam int CX = CW + 1;
    localparam int RW = $clog2(IMG_H + 1);

    typedef enum logic [1:0] {FILL, EMIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     ocol_q, ocol_d;
    logic [RW-1:0]     row_q, row_d;
    logic [1:0]        rsel_q, rsel_d;
    logic [1:0]        top_q, top_d;
    logic [3:0]        k_q, k_d;
    logic              accept;

    logic [DATA_W-1:0] ring_q [3][IMG_W];
    logic [DATA_W-1:0] w_q [9];

    logic [DATA_W-1:0] pe_in_q, pe_filter_q;
    logic              feed_valid_q, window_start_q, window_last_q, frame_done_q;

    logic              emit_d;
    logic [1:0]        roff, coff, rrow;
    logic [2:0]        rsum;
    logic [CW-1:0]     ccol;
    logic [DATA_W-1:0] pix_sel, wgt_sel;

    assign in_ready = (state_q == FILL) && !rst;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        rsel_d  = rsel_q;
        top_d   = top_q;
        k_d     = k_q;
        ocol_d  = ocol_q;
        accept  = 1'b0;
        case (state_q)
            FILL: begin
                accept = in_valid;
                if (in_valid) begin
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d  = '0;
                        row_d  = row_q + 1'b1;
                        rsel_d = (rsel_q == 2'd2) ? 2'd0 : rsel_q + 2'd1;
                        // The ring slot about to be overwritten next holds the window's top row.
                        if (row_q >= RW'(2)) begin
                            if ((STRIDE == 1) || !row_q[0]) begin
                                state_d = EMIT;
                                top_d   = rsel_d;
                                k_d     = '0;
                                ocol_d  = '0;
                            end else if (row_q == RW'(IMG_H - 1)) begin
                                state_d = DONE;
                            end
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (k_q == 4'd8) begin
                    k_d = '0;
                    if ((CX'(ocol_q) + CX'(STRIDE)) > CX'(IMG_W - 3)) begin
                        ocol_d  = '0;
                        state_d = (row_q == RW'(IMG_H)) ? DONE : FILL;
                    end else begin
                        ocol_d = ocol_q + CW'(STRIDE);
                    end
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            DONE: begin
                state_d = FILL;
                col_d   = '0;
                row_d   = '0;
                rsel_d  = '0;
            end
            default: state_d = FILL;
        endcase
    end

    // Outputs are registered from next-state values so a pair appears in the cycle its k is current.
    always_comb begin
        emit_d  = (state_d == EMIT);
        roff    = 2'(k_d / 4'd3);
        coff    = 2'(k_d % 4'd3);
        rsum    = {1'b0, top_d} + {1'b0, roff};
        rrow    = (rsum >= 3'd3) ? 2'(rsum - 3'd3) : rsum[1:0];
        ccol    = ocol_d + CW'(coff);
        pix_sel = ring_q[rrow][ccol];
        wgt_sel = (k_d <= 4'd8) ? w_q[k_d] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FILL;
            col_q          <= '0;
            ocol_q         <= '0;
            row_q          <= '0;
            rsel_q         <= '0;
            top_q          <= '0;
            k_q            <= '0;
            pe_in_q        <= '0;
            pe_filter_q    <= '0;
            feed_valid_q   <= 1'b0;
            window_start_q <= 1'b0;
            window_last_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    ring_q[r][c] <= '0;
                end
            end
            for (int i = 0; i < 9; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            ocol_q  <= ocol_d;
            row_q   <= row_d;
            rsel_q  <= rsel_d;
            top_q   <= top_d;
            k_q     <= k_d;
            if (accept) begin
                ring_q[rsel_q][col_q] <= in_data;
            end
            if (w_we && (w_addr <= 4'd8)) begin
                w_q[w_addr] <= w_data;
            end
            pe_in_q        <= emit_d ? pix_sel : '0;
            pe_filter_q    <= emit_d ? wgt_sel : '0;
            feed_valid_q   <= emit_d;
            window_start_q <= emit_d && (k_d == 4'd0);
            window_last_q  <= emit_d && (k_d == 4'd8);
            frame_done_q   <= (state_d == DONE);
        end
    end

    assign pe_in        = pe_in_q;
    assign pe_filter    = pe_filter_q;
    assign feed_valid   = feed_valid_q;
    assign window_start = window_start_q;
    assign window_last  = window_last_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv3x3_window_feeder.sv
// Self-checking bench for conv3x3_window_feeder against a window-level reference model.
module tb_conv3x3_window_feeder;
    localparam int W = 8;
    localparam int H = 8;
    localparam int D = 8;
`ifdef FEEDER_STRIDE2_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int NWC  = (W - 2 + S - 1) / S;
    localparam int NWR  = (H - 2 + S - 1) / S;
    localparam int NWIN = NWC * NWR;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [D-1:0] in_data = '0;
    logic         in_ready;
    logic         w_we = 1'b0;
    logic [3:0]   w_addr = '0;
    logic [D-1:0] w_data = '0;
    logic [D-1:0] pe_in, pe_filter;
    logic         feed_valid, window_start, window_last, frame_done;

    conv3x3_window_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .pe_in(pe_in), .pe_filter(pe_filter),
        .feed_valid(feed_valid), .window_start(window_start), .window_last(window_last),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [D-1:0] img [H][W];
    logic [D-1:0] wt [9];
    logic [D-1:0] exp_pin[$];
    logic [D-1:0] exp_pf[$];

    logic [D-1:0] cap_pin[$];
    logic [D-1:0] cap_pf[$];
    bit           cap_st[$];
    bit           cap_la[$];
    int           cap_cyc[$];
    int           wl_cyc[$];
    int           fd_cyc[$];
    int           cyc = 0;
    int           idle_bad = 0;
    int           row2_cyc = 0;
    bit           abort = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (feed_valid) begin
                cap_pin.push_back(pe_in);
                cap_pf.push_back(pe_filter);
                cap_st.push_back(window_start);
                cap_la.push_back(window_last);
                cap_cyc.push_back(cyc);
            end else if (pe_in != 0 || pe_filter != 0 || window_start || window_last) begin
                idle_bad++;
            end
            if (window_last) wl_cyc.push_back(cyc);
            if (frame_done) fd_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Reference: windows in raster order, pair k = (kr,kc) of the window at (wr*S, wc*S).
    function automatic void build_exp(input int w4_from, input logic [D-1:0] w4_val);
        exp_pin.delete();
        exp_pf.delete();
        for (int wr = 0; wr < NWR; wr++)
            for (int wc = 0; wc < NWC; wc++)
                for (int k = 0; k < 9; k++) begin
                    exp_pin.push_back(img[wr*S + k/3][wc*S + k%3]);
                    exp_pf.push_back((k == 4 && (wr*NWC + wc) >= w4_from) ? w4_val : wt[k]);
                end
    endfunction

    task automatic set_weight(input logic [3:0] a, input logic [D-1:0] d);
        @(negedge clk);
        w_we = 1'b1; w_addr = a; w_data = d;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic load_weights();
        for (int k = 0; k < 9; k++) set_weight(4'(k), wt[k]);
    endtask

    task automatic ramp_image();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = D'(8*r + c);
    endtask

    task automatic drive_frame(input bit rnd);
        bit acc;
        bit taken;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                while (rnd && !abort && $urandom_range(1, 0) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                in_valid = 1'b1;
                in_data  = img[r][c];
                taken    = 1'b0;
                for (int g = 0; g < 200 && !taken && !abort; g++) begin
                    acc = in_ready;
                    @(posedge clk); #1;
                    taken = acc;
                end
                if (abort) begin
                    in_valid = 1'b0;
                    return;
                end
                if (!taken) begin
                    checks++; errors++;
                    $display("FAIL pixel_accept_timeout row %0d col %0d not accepted within 200 cycles", r, c);
                    in_valid = 1'b0;
                    return;
                end
                if (r == 2 && c == W - 1) row2_cyc = cyc;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_frame(input int fb);
        for (int g = 0; g < 600 && fd_cyc.size() <= fb; g++) @(negedge clk);
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b required 0", in_ready); end
        checks++; if (pe_in !== '0 || pe_filter !== '0) begin errors++; $display("FAIL reset_pe_data got %0h/%0h required 0/0", pe_in, pe_filter); end
        checks++; if ({feed_valid, window_start, window_last, frame_done} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b required 0000", {feed_valid, window_start, window_last, frame_done});
        end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b required 1", in_ready); end
    endtask

    task automatic test_ones();
        logic [D-1:0] first [9] = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
        int b, sum;
        for (int k = 0; k < 9; k++) wt[k] = 8'd1;
        load_weights();
        ramp_image();
        b = cap_pin.size();
        drive_frame(1'b0);
        wait_frame(fd_cyc.size());
        checks++;
        if (cap_pin.size() < b + 9) begin
            errors++; $display("FAIL ones_burst_present got %0d pairs required >=9", cap_pin.size() - b);
            return;
        end
        sum = 0;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (cap_pin[b+k] !== first[k] || cap_pf[b+k] !== 8'd1) begin
                errors++; $display("FAIL ones_pair%0d got %0d/%0d required %0d/1", k, cap_pin[b+k], cap_pf[b+k], first[k]);
            end
            sum += int'(cap_pin[b+k]) * int'(cap_pf[b+k]);
        end
        checks++; if (cap_st[b] !== 1'b1 || cap_la[b+8] !== 1'b1 || cap_st[b+1] !== 1'b0 || cap_la[b+7] !== 1'b0) begin
            errors++; $display("FAIL ones_flags got start=%0b last=%0b required 1/1", cap_st[b], cap_la[b+8]);
        end
        checks++; if (sum != 81) begin errors++; $display("FAIL ones_sum got %0d required 81", sum); end
        checks++; if (cap_cyc[b] != row2_cyc + 1) begin
            errors++; $display("FAIL first_pair_latency got cycle %0d required %0d", cap_cyc[b], row2_cyc + 1);
        end
    endtask

    task automatic test_kweights();
        int b, fb, wb, ib, i, gs, es;
        bit ok;
        for (int k = 0; k < 9; k++) wt[k] = D'(k);
        load_weights();
        ramp_image();
        b = cap_pin.size(); fb = fd_cyc.size(); wb = wl_cyc.size(); ib = idle_bad;
        drive_frame(1'b0);
        wait_frame(fb);
        build_exp(NWIN, '0);
        checks++; if (cap_pin.size() - b != NWIN*9) begin
            errors++; $display("FAIL kw_feed_count got %0d required %0d", cap_pin.size() - b, NWIN*9);
        end
        for (int wi = 0; wi < NWIN; wi++) begin
            ok = 1'b1; gs = 0; es = 0;
            for (int k = 0; k < 9; k++) begin
                i = b + wi*9 + k;
                es += int'(exp_pin[wi*9+k]) * int'(exp_pf[wi*9+k]);
                if (i >= cap_pin.size()) ok = 1'b0;
                else begin
                    gs += int'(cap_pin[i]) * int'(cap_pf[i]);
                    if (cap_pin[i] !== exp_pin[wi*9+k] || cap_pf[i] !== exp_pf[wi*9+k] ||
                        cap_st[i] !== (k == 0) || cap_la[i] !== (k == 8)) ok = 1'b0;
                end
            end
            checks++; if (!ok) begin errors++; $display("FAIL kw_window%0d got sum %0d required %0d", wi, gs, es); end
        end
        for (int wi = 1; wi < NWIN && b + wi*9 + 8 < cap_cyc.size(); wi++) begin
            i = b + wi*9;
            checks++;
            if (cap_cyc[i+8] != cap_cyc[i] + 8 || ((wi % NWC) != 0 && cap_cyc[i] != cap_cyc[i-1] + 1)) begin
                errors++; $display("FAIL kw_back_to_back window %0d got start cycle %0d required %0d", wi, cap_cyc[i], cap_cyc[i-1] + 1);
            end
        end
        checks++; if (fd_cyc.size() - fb != 1) begin
            errors++; $display("FAIL kw_frame_done_count got %0d required 1", fd_cyc.size() - fb);
        end else begin
            checks++;
`ifdef FEEDER_STRIDE2_EN
            if (wl_cyc.size() == wb || fd_cyc[fb] <= wl_cyc[wl_cyc.size()-1]) begin
                errors++; $display("FAIL kw_frame_done_timing got cycle %0d required after last window", fd_cyc[fb]);
            end
`else
            if (wl_cyc.size() == wb || fd_cyc[fb] != wl_cyc[wl_cyc.size()-1] + 1) begin
                errors++; $display("FAIL kw_frame_done_timing got cycle %0d required one after last window_last", fd_cyc[fb]);
            end
`endif
        end
        checks++; if (idle_bad != ib) begin errors++; $display("FAIL kw_idle_zero got %0d nonzero idle cycles required 0", idle_bad - ib); end
    endtask

    task automatic test_random_valid();
        int b, fb, i;
        bit ok;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = D'($urandom);
        for (int k = 0; k < 9; k++) wt[k] = D'($urandom);
        load_weights();
        b = cap_pin.size(); fb = fd_cyc.size();
        drive_frame(1'b1);
        wait_frame(fb);
        build_exp(NWIN, '0);
        checks++; if (cap_pin.size() - b != NWIN*9) begin
            errors++; $display("FAIL rv_feed_count got %0d required %0d", cap_pin.size() - b, NWIN*9);
        end
        for (int wi = 0; wi < NWIN; wi++) begin
            ok = 1'b1;
            for (int k = 0; k < 9; k++) begin
                i = b + wi*9 + k;
                if (i >= cap_pin.size() || cap_pin[i] !== exp_pin[wi*9+k] || cap_pf[i] !== exp_pf[wi*9+k]) ok = 1'b0;
            end
            checks++; if (!ok) begin
                errors++; $display("FAIL rv_window%0d got first pixel %0h required %0h", wi,
                                   (b + wi*9 < cap_pin.size()) ? cap_pin[b + wi*9] : 8'hxx, exp_pin[wi*9]);
            end
        end
        checks++; if (fd_cyc.size() - fb != 1) begin errors++; $display("FAIL rv_frame_done_count got %0d required 1", fd_cyc.size() - fb); end
    endtask

    task automatic test_weight_write();
        int b, fb, i;
        bit ok;
        wt[4] = 8'h3C;
        set_weight(4'd4, wt[4]);
        set_weight(4'd12, 8'hFF);
        b = cap_pin.size(); fb = fd_cyc.size();
        fork
            drive_frame(1'b0);
            begin
                int n;
                bit hit;
                n = 0; hit = 1'b0;
                for (int g = 0; g < 1500 && !hit; g++) begin
                    @(negedge clk);
                    if (window_start) begin n++; if (n == 2) hit = 1'b1; end
                end
                if (hit) begin
                    w_we = 1'b1; w_addr = 4'd4; w_data = 8'h05;
                    @(negedge clk);
                    w_we = 1'b0;
                end
            end
        join
        wait_frame(fb);
        build_exp(1, 8'h05);
        wt[4] = 8'h05;
        for (int wi = 0; wi < NWIN; wi++) begin
            ok = 1'b1;
            for (int k = 0; k < 9; k++) begin
                i = b + wi*9 + k;
                if (i >= cap_pin.size() || cap_pin[i] !== exp_pin[wi*9+k] || cap_pf[i] !== exp_pf[wi*9+k]) ok = 1'b0;
            end
            checks++; if (!ok) begin
                errors++; $display("FAIL ww_window%0d got k4 weight %0h required %0h", wi,
                                   (b + wi*9 + 4 < cap_pf.size()) ? cap_pf[b + wi*9 + 4] : 8'hxx, exp_pf[wi*9+4]);
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        logic [D-1:0] first [9] = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
        int b, sum;
        ramp_image();
        fork
            drive_frame(1'b0);
            begin
                int n;
                bit hit;
                n = 0; hit = 1'b0;
                for (int g = 0; g < 1500 && !hit; g++) begin
                    @(negedge clk);
                    if (feed_valid) begin n++; if (n == 3*9 + 6) hit = 1'b1; end
                end
                rst = 1'b1;
                #1;
                checks++; if (!hit) begin errors++; $display("FAIL mid_reset_reach got %0d pairs required %0d", n, 3*9 + 6); end
                checks++; if ({pe_in, pe_filter, feed_valid, window_start, window_last, frame_done, in_ready} !== '0) begin
                    errors++; $display("FAIL mid_reset_outputs got %0h/%0h flags %b required all 0", pe_in, pe_filter,
                                       {feed_valid, window_start, window_last, frame_done, in_ready});
                end
                abort = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        rst = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 9; k++) wt[k] = 8'd1;
        load_weights();
        b = cap_pin.size();
        drive_frame(1'b0);
        wait_frame(fd_cyc.size());
        checks++;
        if (cap_pin.size() < b + 9) begin
            errors++; $display("FAIL post_reset_burst got %0d pairs required >=9", cap_pin.size() - b);
            return;
        end
        sum = 0;
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (cap_pin[b+k] !== first[k] || cap_pf[b+k] !== 8'd1) begin
                errors++; $display("FAIL post_reset_pair%0d got %0d/%0d required %0d/1", k, cap_pin[b+k], cap_pf[b+k], first[k]);
            end
            sum += int'(cap_pin[b+k]) * int'(cap_pf[b+k]);
        end
        checks++; if (sum != 81) begin errors++; $display("FAIL post_reset_sum got %0d required 81", sum); end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_kweights();
        test_random_valid();
        test_weight_write();
        test_reset_mid_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
